// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
// The FSM state encoding is fixed here so every user agrees on it.
package regfile_dump_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_IDX_W  = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks register indices FIRST_REG..LAST_REG and streams each value out over a
// valid/ready port. Define DUMP_SKIP_ZERO_EN to suppress beats for zero registers.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_IDX_W-1:0]  rf_addr,
  input  logic [REG_DATA_W-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_IDX_W-1:0]  out_idx,
  output logic [REG_DATA_W-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

  dump_state_t           state_reg, state_next;
  logic [REG_IDX_W-1:0]  idx_reg, idx_next;
  logic [REG_IDX_W-1:0]  out_idx_reg, out_idx_next;
  logic [REG_DATA_W-1:0] out_data_reg, out_data_next;
  logic                  out_last_reg, out_last_next;
  logic                  idx_at_last;

  assign idx_at_last = (idx_reg == LAST_IDX);

`ifdef DUMP_SKIP_ZERO_EN
  // One nonzero beat is held back until the scan proves whether it is the last.
  logic                  pend_vld_reg, pend_vld_next;
  logic [REG_IDX_W-1:0]  pend_idx_reg, pend_idx_next;
  logic [REG_DATA_W-1:0] pend_data_reg, pend_data_next;
  logic                  scan_end_reg, scan_end_next;
  logic                  rf_nonzero;

  assign rf_nonzero = (rf_data != '0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= FIRST_IDX;
      out_idx_reg   <= '0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
`ifdef DUMP_SKIP_ZERO_EN
      pend_vld_reg  <= 1'b0;
      pend_idx_reg  <= '0;
      pend_data_reg <= '0;
      scan_end_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      out_idx_reg   <= out_idx_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
`ifdef DUMP_SKIP_ZERO_EN
      pend_vld_reg  <= pend_vld_next;
      pend_idx_reg  <= pend_idx_next;
      pend_data_reg <= pend_data_next;
      scan_end_reg  <= scan_end_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    out_idx_next   = out_idx_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    rf_addr        = '0;
`ifdef DUMP_SKIP_ZERO_EN
    pend_vld_next  = pend_vld_reg;
    pend_idx_next  = pend_idx_reg;
    pend_data_next = pend_data_reg;
    scan_end_next  = scan_end_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          state_next    = ST_READ;
          idx_next      = FIRST_IDX;
`ifdef DUMP_SKIP_ZERO_EN
          pend_vld_next = 1'b0;
          scan_end_next = 1'b0;
`endif
        end
      end

      ST_READ: begin
        rf_addr = idx_reg;
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
`ifdef DUMP_SKIP_ZERO_EN
          if (rf_nonzero) begin
            if (pend_vld_reg) begin
              // A newer nonzero proves the held beat is not the last one.
              out_idx_next   = pend_idx_reg;
              out_data_next  = pend_data_reg;
              out_last_next  = 1'b0;
              pend_idx_next  = idx_reg;
              pend_data_next = rf_data;
              state_next     = ST_SEND;
            end else if (idx_at_last) begin
              out_idx_next  = idx_reg;
              out_data_next = rf_data;
              out_last_next = 1'b1;
              state_next    = ST_SEND;
            end else begin
              pend_vld_next  = 1'b1;
              pend_idx_next  = idx_reg;
              pend_data_next = rf_data;
            end
          end else if (idx_at_last) begin
            if (pend_vld_reg) begin
              out_idx_next  = pend_idx_reg;
              out_data_next = pend_data_reg;
              out_last_next = 1'b1;
              pend_vld_next = 1'b0;
              state_next    = ST_SEND;
            end else begin
              state_next = ST_DONE;
            end
          end
          if (idx_at_last) begin
            scan_end_next = 1'b1;
          end else begin
            idx_next = idx_reg + 5'd1;
          end
`else
          out_idx_next  = idx_reg;
          out_data_next = rf_data;
          out_last_next = idx_at_last;
          state_next    = ST_SEND;
`endif
        end
      end

      ST_SEND: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (out_ready) begin
`ifdef DUMP_SKIP_ZERO_EN
          if (!scan_end_reg) begin
            state_next = ST_READ;
          end else if (pend_vld_reg) begin
            out_idx_next  = pend_idx_reg;
            out_data_next = pend_data_reg;
            out_last_next = 1'b1;
            pend_vld_next = 1'b0;
          end else begin
            state_next = ST_DONE;
          end
`else
          if (idx_at_last) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_reg + 5'd1;
            state_next = ST_READ;
          end
`endif
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign out_valid = (state_reg == ST_SEND);
  assign out_idx   = out_idx_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg != ST_IDLE);
  // An abort landing on the DONE cycle cancels the completion pulse.
  assign done      = (state_reg == ST_DONE) && !abort;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full-range instance plus a single-register
// instance (FIRST_REG=LAST_REG=17); skip-zero vectors run when DUMP_SKIP_ZERO_EN is set.
module tb_regfile_dump_reader;

  logic        clk;
  logic        reset_n;

  logic        start_a, abort_a, out_ready_a;
  logic [4:0]  rf_addr_a, out_idx_a;
  logic [31:0] rf_data_a, out_data_a;
  logic        out_valid_a, out_last_a, busy_a, done_a;
  logic [31:0] mem_a [32];

  logic        start_b, abort_b, out_ready_b;
  logic [4:0]  rf_addr_b, out_idx_b;
  logic [31:0] rf_data_b, out_data_b;
  logic        out_valid_b, out_last_b, busy_b, done_b;
  logic [31:0] mem_b [32];

  int n_vec  = 0;
  int n_miss = 0;

  assign rf_data_a = mem_a[rf_addr_a];
  assign rf_data_b = mem_b[rf_addr_b];

  regfile_dump_reader u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
    .rf_addr(rf_addr_a), .rf_data(rf_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_idx(out_idx_a), .out_data(out_data_a),
    .out_last(out_last_a), .busy(busy_a), .done(done_a)
  );

  regfile_dump_reader #(.FIRST_REG(17), .LAST_REG(17)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
    .rf_addr(rf_addr_b), .rf_data(rf_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_idx(out_idx_b), .out_data(out_data_b),
    .out_last(out_last_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Bounded wait for a presented beat with the given index on instance A.
  task automatic wait_beat_a(input int idx, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (out_valid_a && out_idx_a == 5'(idx)) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check_val("wait_beat_timeout", 32'(idx), 32'hffff_ffff);
  endtask

`ifdef DUMP_SKIP_ZERO_EN
  // Collects every beat of one dump on instance A until done, bounded.
  int          got_n;
  logic [4:0]  got_idx [32];
  logic [31:0] got_data [32];
  logic        got_last [32];

  task automatic collect_a(output bit saw_done);
    saw_done = 1'b0;
    got_n = 0;
    for (int c = 0; c < 400 && !saw_done; c++) begin
      @(negedge clk);
      if (done_a) saw_done = 1'b1;
      else if (out_valid_a && got_n < 32) begin
        got_idx[got_n]  = out_idx_a;
        got_data[got_n] = out_data_a;
        got_last[got_n] = out_last_a;
        got_n++;
      end
    end
    if (!saw_done) check_val("collect_done_timeout", 32'd0, 32'd1);
  endtask
`endif

  initial begin
    bit ok;
    bit saw_done;
    bit stalled;
    bit flag;
    int exp_idx;
    int cyc;
    int last_cyc;
    logic [31:0] exp_data;

    reset_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; out_ready_a = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 32'(i * 4);
      mem_b[i] = 32'(i * 4);
    end
    mem_a[2]  = 32'h2ffc;
    mem_b[17] = 32'h5d;

    repeat (3) @(negedge clk);
    check_val("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check_val("rst_busy", {31'd0, busy_a}, 32'd0);
    check_val("rst_done", {31'd0, done_a}, 32'd0);
    check_val("rst_rf_addr", {27'd0, rf_addr_a}, 32'd0);
    check_val("rst_out_idx", {27'd0, out_idx_a}, 32'd0);
    check_val("rst_out_data", out_data_a, 32'd0);
    check_val("rst_out_last", {31'd0, out_last_a}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

`ifndef DUMP_SKIP_ZERO_EN
    // Full dump with a 5-cycle stall on idx 3 and a stray start at idx 20.
    pulse_start_a();
    check_val("lat_read_valid", {31'd0, out_valid_a}, 32'd0);
    check_val("lat_read_busy", {31'd0, busy_a}, 32'd1);
    exp_idx = 0; stalled = 1'b0; saw_done = 1'b0; cyc = 0; last_cyc = -10;
    while (!saw_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0;
      if (done_a) begin
        saw_done = 1'b1;
        check_val("dump_beat_count", 32'(exp_idx), 32'd32);
        check_val("done_one_after_last", 32'(cyc - last_cyc), 32'd1);
        check_val("done_rf_addr", {27'd0, rf_addr_a}, 32'd0);
      end else if (out_valid_a) begin
        if (exp_idx == 0) check_val("first_beat_latency", 32'(cyc), 32'd1);
        exp_data = (exp_idx == 2) ? 32'h2ffc : 32'(exp_idx * 4);
        check_val("beat_idx", {27'd0, out_idx_a}, 32'(exp_idx));
        check_val("beat_data", out_data_a, exp_data);
        check_val("beat_last", {31'd0, out_last_a}, (exp_idx == 31) ? 32'd1 : 32'd0);
        if (exp_idx == 3 && !stalled) begin
          out_ready_a = 1'b0;
          repeat (5) begin
            @(negedge clk);
            cyc++;
            check_val("stall_valid", {31'd0, out_valid_a}, 32'd1);
            check_val("stall_idx", {27'd0, out_idx_a}, 32'd3);
            check_val("stall_data", out_data_a, 32'hc);
          end
          out_ready_a = 1'b1;
          stalled = 1'b1;
        end
        if (exp_idx == 20) start_a = 1'b1;
        last_cyc = cyc;
        exp_idx++;
      end
    end
    if (!saw_done) check_val("dump_done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check_val("done_pulse_width", {31'd0, done_a}, 32'd0);
    check_val("idle_after_done", {31'd0, busy_a}, 32'd0);

    // Abort colliding with a handshake at idx 10.
    pulse_start_a();
    wait_beat_a(10, ok);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check_val("abort_valid", {31'd0, out_valid_a}, 32'd0);
    check_val("abort_busy", {31'd0, busy_a}, 32'd0);
    flag = 1'b0;
    repeat (6) begin
      if (done_a) flag = 1'b1;
      @(negedge clk);
    end
    check_val("abort_no_done", {31'd0, flag}, 32'd0);
    pulse_start_a();
    @(negedge clk);
    check_val("restart_valid", {31'd0, out_valid_a}, 32'd1);
    check_val("restart_idx", {27'd0, out_idx_a}, 32'd0);
`endif

    // Asynchronous reset mid-dump at idx 7.
`ifdef DUMP_SKIP_ZERO_EN
    pulse_start_a();
    wait_beat_a(7, ok);
`else
    wait_beat_a(7, ok);
`endif
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_valid", {31'd0, out_valid_a}, 32'd0);
    check_val("arst_busy", {31'd0, busy_a}, 32'd0);
    check_val("arst_idx", {27'd0, out_idx_a}, 32'd0);
    check_val("arst_data", out_data_a, 32'd0);
    check_val("arst_last", {31'd0, out_last_a}, 32'd0);
    check_val("arst_rf_addr", {27'd0, rf_addr_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid_a || busy_a) flag = 1'b1;
    end
    check_val("post_rst_quiet", {31'd0, flag}, 32'd0);

    // Start and abort together in IDLE: abort wins.
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    check_val("start_abort_idle", {31'd0, busy_a}, 32'd0);

    // Single-register range on instance B.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_val("b_read_addr", {27'd0, rf_addr_b}, 32'd17);
    check_val("b_read_valid", {31'd0, out_valid_b}, 32'd0);
    @(negedge clk);
    check_val("b_valid", {31'd0, out_valid_b}, 32'd1);
    check_val("b_idx", {27'd0, out_idx_b}, 32'd17);
    check_val("b_data", out_data_b, 32'h5d);
    check_val("b_last", {31'd0, out_last_b}, 32'd1);
    @(negedge clk);
    check_val("b_done", {31'd0, done_b}, 32'd1);
    @(negedge clk);
    check_val("b_done_width", {31'd0, done_b}, 32'd0);
    check_val("b_idle", {31'd0, busy_b}, 32'd0);

`ifdef DUMP_SKIP_ZERO_EN
    for (int i = 0; i < 32; i++) mem_a[i] = 32'd0;
    mem_a[2] = 32'h2ffc;
    mem_a[5] = 32'h1;
    pulse_start_a();
    collect_a(saw_done);
    check_val("skip_beat_count", 32'(got_n), 32'd2);
    if (got_n == 2) begin
      check_val("skip_b0_idx", {27'd0, got_idx[0]}, 32'd2);
      check_val("skip_b0_data", got_data[0], 32'h2ffc);
      check_val("skip_b0_last", {31'd0, got_last[0]}, 32'd0);
      check_val("skip_b1_idx", {27'd0, got_idx[1]}, 32'd5);
      check_val("skip_b1_data", got_data[1], 32'h1);
      check_val("skip_b1_last", {31'd0, got_last[1]}, 32'd1);
    end
    @(negedge clk);
    mem_a[2] = 32'd0;
    mem_a[5] = 32'd0;
    pulse_start_a();
    collect_a(saw_done);
    check_val("skip_zero_beats", 32'(got_n), 32'd0);
    check_val("skip_zero_done", {31'd0, saw_done}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
